// File: rtl/vend_pkg.sv
// Shared types and constants for the N-product vending controller.
package vend_pkg;

  // Controller state, exported on the state port for the display path.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CREDIT = 3'd1,
    VEND   = 3'd2,
    CHANGE = 3'd3
  } vend_state_t;

  localparam int unsigned MAX_PRODUCTS = 8;

  // Coin values: bit0 of coin_in is the small coin, bit1 the large coin.
  localparam int unsigned COIN_VAL [2] = '{1, 5};

  // Product prices, indexed by prod_sel.
  localparam int unsigned PRICE [MAX_PRODUCTS] = '{3, 7, 12, 15, 20, 25, 30, 50};

  // Total value of all coin strobes present in one cycle.
  function automatic int unsigned coin_sum(input logic [1:0] coins);
    int unsigned sum;
    sum = 32'd0;
    if (coins[0]) sum = sum + COIN_VAL[0];
    if (coins[1]) sum = sum + COIN_VAL[1];
    return sum;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for an already-debounced level input.
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // Registered copy of the level, cleared by the active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/vending_ctrl_n.sv
// N-product vending controller: coin accumulation, price check, one-cycle
// dispense and paced change return. All outputs come straight from flops.
module vending_ctrl_n
  import vend_pkg::*;
#(
  parameter int unsigned NUM_PRODUCTS = 4,
  parameter int unsigned CREDIT_W     = 8,
  parameter int unsigned MAX_CREDIT   = 99,
  parameter int unsigned TIMEOUT_CYC  = 1_000_000,
  parameter int unsigned PULSE_GAP    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin_in,
  input  logic [2:0]          prod_sel,
  input  logic                buy,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic [2:0]          state,
  output logic                dispense,
  output logic [2:0]          dispense_id,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                insufficient,
  output logic                sel_error
);

  localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned GAP_W = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;

  vend_state_t         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                dispense_q, dispense_d;
  logic [2:0]          dispense_id_q, dispense_id_d;
  logic                change_pulse_q, change_pulse_d;
  logic                coin_reject_q, coin_reject_d;
  logic                insufficient_q, insufficient_d;
  logic                sel_error_q, sel_error_d;

  logic                buy_e, cancel_e;
  logic                coin_any, coin_take, sel_legal, price_ok;
  logic                activity, buy_ok, to_hit, pulse_now;
  logic [CREDIT_W:0]   credit_sum;
  logic [CREDIT_W-1:0] credit_in;
  int unsigned         price_sel;

  edge_rise u_buy_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (buy),
    .rise_o (buy_e)
  );

  edge_rise u_cancel_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (cancel),
    .rise_o (cancel_e)
  );

  // Shared decisions: coin acceptance, price check against post-coin credit,
  // timeout hit and change-pulse timing.
  always_comb begin
    coin_any   = |coin_in;
    credit_sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin_sum(coin_in));
    // Coins only count in IDLE/CREDIT and only if the whole cycle's sum fits.
    coin_take  = coin_any && (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT)) &&
                 (state_q == IDLE || state_q == CREDIT);
    credit_in  = coin_take ? credit_sum[CREDIT_W-1:0] : credit_q;
    sel_legal  = 32'(prod_sel) < NUM_PRODUCTS;
    price_sel  = PRICE[prod_sel];
    price_ok   = 32'(credit_in) >= price_sel;
    activity   = coin_any || buy_e || cancel_e;
    // Cancel wins over a simultaneous buy.
    buy_ok     = (state_q == CREDIT) && buy_e && !cancel_e && sel_legal && price_ok;
    to_hit     = (state_q == CREDIT) && !activity && (to_q == TO_W'(TIMEOUT_CYC - 1));
    pulse_now  = (state_q == CHANGE) && (gap_q == '0) && (credit_q != '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (coin_take) state_d = CREDIT;
      end
      CREDIT: begin
        if (buy_e && cancel_e)  state_d = CHANGE;
        else if (cancel_e)      state_d = CHANGE;
        else if (buy_ok)        state_d = VEND;
        else if (to_hit)        state_d = CHANGE;
      end
      VEND: begin
        // Price was already deducted on entry.
        state_d = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (credit_q == '0)                           state_d = IDLE;
        else if (pulse_now && credit_q == CREDIT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered pulse outputs for the coming cycle.
  always_comb begin
    credit_d       = credit_q;
    to_d           = to_q;
    gap_d          = gap_q;
    dispense_d     = 1'b0;
    dispense_id_d  = dispense_id_q;
    change_pulse_d = 1'b0;
    coin_reject_d  = coin_any && !coin_take;
    insufficient_d = 1'b0;
    sel_error_d    = 1'b0;
    case (state_q)
      IDLE: begin
        credit_d = credit_in;
        to_d     = '0;
        gap_d    = '0;
      end
      CREDIT: begin
        credit_d = credit_in;
        gap_d    = '0;
        if (activity || to_hit) to_d = '0;
        else                    to_d = to_q + TO_W'(1);
        if (buy_e && !cancel_e) begin
          if (!sel_legal) begin
            sel_error_d = 1'b1;
          end else if (!price_ok) begin
            insufficient_d = 1'b1;
          end else begin
            dispense_d    = 1'b1;
            dispense_id_d = prod_sel;
            credit_d      = credit_in - CREDIT_W'(price_sel);
          end
        end
      end
      VEND: begin
        to_d  = '0;
        gap_d = '0;
      end
      CHANGE: begin
        to_d = '0;
        // gap_q enters at zero, so the first pulse follows the entry cycle.
        if (pulse_now) begin
          change_pulse_d = 1'b1;
          credit_d       = credit_q - CREDIT_W'(1);
          gap_d          = GAP_W'(PULSE_GAP - 1);
        end else if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        credit_d = '0;
        to_d     = '0;
        gap_d    = '0;
      end
    endcase
  end

  // Datapath and output registers; reset discards any remaining credit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      credit_q       <= '0;
      to_q           <= '0;
      gap_q          <= '0;
      dispense_q     <= 1'b0;
      dispense_id_q  <= 3'd0;
      change_pulse_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
      sel_error_q    <= 1'b0;
    end else begin
      credit_q       <= credit_d;
      to_q           <= to_d;
      gap_q          <= gap_d;
      dispense_q     <= dispense_d;
      dispense_id_q  <= dispense_id_d;
      change_pulse_q <= change_pulse_d;
      coin_reject_q  <= coin_reject_d;
      insufficient_q <= insufficient_d;
      sel_error_q    <= sel_error_d;
    end
  end

  assign credit       = credit_q;
  assign state        = state_q;
  assign dispense     = dispense_q;
  assign dispense_id  = dispense_id_q;
  assign change_pulse = change_pulse_q;
  assign coin_reject  = coin_reject_q;
  assign insufficient = insufficient_q;
  assign sel_error    = sel_error_q;

endmodule

// File: tb/tb_vending_ctrl_n.sv
// Scoreboard bench for vending_ctrl_n: stimulus pushes expected pulse events,
// a negedge monitor pops and compares each pulse the controller emits.
module tb_vending_ctrl_n;

  localparam int unsigned NUM_PRODUCTS = 4;
  localparam int unsigned CREDIT_W     = 8;
  localparam int unsigned MAX_CREDIT   = 99;
  localparam int unsigned TIMEOUT_CYC  = 16;
  localparam int unsigned PULSE_GAP    = 4;

  localparam int unsigned S_IDLE = 0, S_CREDIT = 1, S_CHANGE = 3;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [1:0]          coin_in = 2'b00;
  logic [2:0]          prod_sel = 3'd0;
  logic                buy = 1'b0;
  logic                cancel = 1'b0;
  logic [CREDIT_W-1:0] credit;
  logic [2:0]          state;
  logic                dispense, change_pulse, coin_reject, insufficient, sel_error;
  logic [2:0]          dispense_id;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_chg = 0;

  // a: primary value (id or credit), b: credit for dispense, gap: check spacing.
  typedef struct {
    int unsigned a;
    int unsigned b;
    bit          gap;
  } exp_t;

  exp_t q_disp[$];
  exp_t q_chg[$];
  exp_t q_rej[$];
  exp_t q_ins[$];
  exp_t q_sel[$];

  vending_ctrl_n #(
    .NUM_PRODUCTS (NUM_PRODUCTS),
    .CREDIT_W     (CREDIT_W),
    .MAX_CREDIT   (MAX_CREDIT),
    .TIMEOUT_CYC  (TIMEOUT_CYC),
    .PULSE_GAP    (PULSE_GAP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .coin_in      (coin_in),
    .prod_sel     (prod_sel),
    .buy          (buy),
    .cancel       (cancel),
    .credit       (credit),
    .state        (state),
    .dispense     (dispense),
    .dispense_id  (dispense_id),
    .change_pulse (change_pulse),
    .coin_reject  (coin_reject),
    .insufficient (insufficient),
    .sel_error    (sel_error)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int unsigned a, input int unsigned b, input bit gap);
    exp_t e;
    e.a = a;
    e.b = b;
    e.gap = gap;
    return e;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL unexpected_%s: got pulse required none (cyc %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] c);
    coin_in = c;
    tick();
    coin_in = 2'b00;
  endtask

  task automatic press_buy(input logic [2:0] sel);
    prod_sel = sel;
    buy = 1'b1;
    tick();
    buy = 1'b0;
    tick();
  endtask

  // Expect change pulses leaving credit from-1 down to 0, evenly spaced.
  task automatic push_chg(input int unsigned from);
    for (int k = int'(from) - 1; k >= 0; k--)
      q_chg.push_back(mk(k, 0, (k != int'(from) - 1)));
  endtask

  task automatic wait_state(input string name, input int unsigned s, input int limit);
    int n = 0;
    while (32'(state) != s && n < limit) begin
      tick();
      n++;
    end
    check(name, 32'(state), s);
  endtask

  // Monitor: every pulse output is matched against its own expectation queue.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (dispense) begin
      $display("[%0d] dispense id=%0d credit=%0d", cyc, dispense_id, credit);
      if (q_disp.size() == 0) unexpected("dispense");
      else begin
        e = q_disp.pop_front();
        check("dispense_id", 32'(dispense_id), e.a);
        check("dispense_credit", 32'(credit), e.b);
      end
    end
    if (change_pulse) begin
      $display("[%0d] change_pulse credit=%0d", cyc, credit);
      if (q_chg.size() == 0) unexpected("change_pulse");
      else begin
        e = q_chg.pop_front();
        check("change_credit", 32'(credit), e.a);
        if (e.gap) check("change_gap", 32'(cyc - last_chg), PULSE_GAP);
      end
      last_chg = cyc;
    end
    if (coin_reject) begin
      $display("[%0d] coin_reject credit=%0d", cyc, credit);
      if (q_rej.size() == 0) unexpected("coin_reject");
      else begin
        e = q_rej.pop_front();
        check("reject_credit", 32'(credit), e.a);
      end
    end
    if (insufficient) begin
      $display("[%0d] insufficient credit=%0d", cyc, credit);
      if (q_ins.size() == 0) unexpected("insufficient");
      else begin
        e = q_ins.pop_front();
        check("insufficient_credit", 32'(credit), e.a);
      end
    end
    if (sel_error) begin
      $display("[%0d] sel_error credit=%0d", cyc, credit);
      if (q_sel.size() == 0) unexpected("sel_error");
      else begin
        e = q_sel.pop_front();
        check("sel_error_credit", 32'(credit), e.a);
      end
    end
  end

  initial begin
    int n;

    // Reset state.
    reset = 1'b0;
    repeat (3) tick();
    check("reset_state", 32'(state), S_IDLE);
    check("reset_credit", 32'(credit), 0);
    check("reset_dispense_id", 32'(dispense_id), 0);
    check("reset_pulses", 32'({dispense, change_pulse, coin_reject, insufficient, sel_error}), 0);
    reset = 1'b1;
    tick();

    // 5 then 1 coin.
    coin(2'b10);
    check("coin5_credit", 32'(credit), 5);
    check("coin5_state", 32'(state), S_CREDIT);
    coin(2'b01);
    check("coin1_credit", 32'(credit), 6);

    // Insufficient for product 1 (price 7), then top up and buy.
    q_ins.push_back(mk(6, 0, 0));
    press_buy(3'd1);
    check("after_insufficient_credit", 32'(credit), 6);
    check("after_insufficient_state", 32'(state), S_CREDIT);
    coin(2'b10);
    check("topup_credit", 32'(credit), 11);
    q_disp.push_back(mk(1, 4, 0));
    push_chg(4);
    press_buy(3'd1);
    wait_state("vend_return_idle", S_IDLE, 100);
    check("vend_final_credit", 32'(credit), 0);

    // Ceiling: reach 97, a 6 is refused, a 1 is accepted.
    for (int i = 0; i < 19; i++) coin(2'b10);
    coin(2'b01);
    coin(2'b01);
    check("build97_credit", 32'(credit), 97);
    q_rej.push_back(mk(97, 0, 0));
    coin(2'b11);
    check("reject_keeps_credit", 32'(credit), 97);
    coin(2'b01);
    check("ceiling_credit", 32'(credit), 98);
    push_chg(98);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    wait_state("cancel98_idle", S_IDLE, 600);
    check("cancel98_credit", 32'(credit), 0);

    // Buy and cancel in the same cycle: cancel wins, no dispense.
    coin(2'b10);
    coin(2'b10);
    check("credit10", 32'(credit), 10);
    push_chg(10);
    prod_sel = 3'd0;
    buy = 1'b1;
    cancel = 1'b1;
    tick();
    buy = 1'b0;
    cancel = 1'b0;
    wait_state("buycancel_idle", S_IDLE, 200);
    check("buycancel_credit", 32'(credit), 0);

    // Timeout refund with a coin refused during the change phase.
    coin(2'b01);
    coin(2'b01);
    coin(2'b01);
    check("credit3", 32'(credit), 3);
    push_chg(3);
    n = 0;
    while (32'(state) != S_CHANGE && n < 40) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), TIMEOUT_CYC);
    // This coin coincides with the first change pulse (3 -> 2).
    q_rej.push_back(mk(2, 0, 0));
    coin(2'b01);
    wait_state("timeout_idle", S_IDLE, 100);
    check("timeout_credit", 32'(credit), 0);

    // Illegal selection, then reset in the middle of CHANGE.
    coin(2'b10);
    q_sel.push_back(mk(5, 0, 0));
    press_buy(3'd5);
    check("selerr_state", 32'(state), S_CREDIT);
    check("selerr_credit", 32'(credit), 5);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_enter_change", 32'(state), S_CHANGE);
    check("cancel_change_credit", 32'(credit), 5);
    reset = 1'b0;
    tick();
    check("midchange_reset_credit", 32'(credit), 0);
    check("midchange_reset_state", 32'(state), S_IDLE);
    check("midchange_reset_pulse", 32'(change_pulse), 0);
    reset = 1'b1;
    repeat (8) tick();

    check("left_dispense", 32'(q_disp.size()), 0);
    check("left_change", 32'(q_chg.size()), 0);
    check("left_reject", 32'(q_rej.size()), 0);
    check("left_insufficient", 32'(q_ins.size()), 0);
    check("left_sel_error", 32'(q_sel.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
